// File: rtl/ex_stage_pkg.sv
// Shared operation codes for ID/EX plus divider state encoding.
// Single source for ALUctrl values; ID decodes into these, EX consumes them.
package ex_stage_pkg;

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_SLL   = 5'd2;
    localparam logic [4:0] OP_SLT   = 5'd3;
    localparam logic [4:0] OP_SLTU  = 5'd4;
    localparam logic [4:0] OP_XOR   = 5'd5;
    localparam logic [4:0] OP_SRL   = 5'd6;
    localparam logic [4:0] OP_SRA   = 5'd7;
    localparam logic [4:0] OP_OR    = 5'd8;
    localparam logic [4:0] OP_AND   = 5'd9;
    localparam logic [4:0] OP_PASSB = 5'd10;
    localparam logic [4:0] OP_BEQ   = 5'd11;
    localparam logic [4:0] OP_BNE   = 5'd12;
    localparam logic [4:0] OP_BLT   = 5'd13;
    localparam logic [4:0] OP_BGE   = 5'd14;
    localparam logic [4:0] OP_BLTU  = 5'd15;
    localparam logic [4:0] OP_BGEU  = 5'd16;
    localparam logic [4:0] OP_DIV   = 5'd17;
    localparam logic [4:0] OP_DIVU  = 5'd18;
    localparam logic [4:0] OP_REM   = 5'd19;
    localparam logic [4:0] OP_REMU  = 5'd20;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    function automatic logic is_div_op(input logic [4:0] op);
        return (op >= OP_DIV) && (op <= OP_REMU);
    endfunction

    function automatic logic is_branch_op(input logic [4:0] op);
        return (op >= OP_BEQ) && (op <= OP_BGEU);
    endfunction

endpackage

// File: rtl/ex_stage_div.sv
// Iterative radix-2 restoring divider: 32 BUSY cycles, or straight to DONE for b==0 / signed overflow.
// Result valid only while done is high; flush aborts to IDLE from any state.
module div_unit
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    div_state_e  state;
    logic [4:0]  cnt;
    logic [31:0] quo, rem, dvs;
    logic        neg_q, neg_r, is_rem;

    logic        sgn;
    logic [31:0] abs_a, abs_b;
    logic [32:0] rem_sh, diff;

    assign sgn    = (op == OP_DIV) || (op == OP_REM);
    assign abs_a  = (sgn && a[31]) ? -a : a;
    assign abs_b  = (sgn && b[31]) ? -b : b;
    assign rem_sh = {rem, quo[31]};
    assign diff   = rem_sh - {1'b0, dvs};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= DIV_IDLE;
            cnt    <= 5'd0;
            quo    <= 32'd0;
            rem    <= 32'd0;
            dvs    <= 32'd0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            is_rem <= 1'b0;
        end else if (flush) begin
            state <= DIV_IDLE;
            cnt   <= 5'd0;
        end else begin
            unique case (state)
                DIV_IDLE: if (start) begin
                    is_rem <= (op == OP_REM) || (op == OP_REMU);
                    cnt    <= 5'd31;
                    // Special results are stored final, so sign correction is disabled for them.
                    if (b == 32'd0) begin
                        quo   <= 32'hFFFF_FFFF;
                        rem   <= a;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                        state <= DIV_DONE;
                    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        quo   <= 32'h8000_0000;
                        rem   <= 32'd0;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                        state <= DIV_DONE;
                    end else begin
                        quo   <= abs_a;
                        rem   <= 32'd0;
                        dvs   <= abs_b;
                        neg_q <= sgn && (a[31] ^ b[31]);
                        neg_r <= sgn && a[31];
                        state <= DIV_BUSY;
                    end
                end
                DIV_BUSY: begin
                    if (!diff[32]) begin
                        rem <= diff[31:0];
                        quo <= {quo[30:0], 1'b1};
                    end else begin
                        rem <= rem_sh[31:0];
                        quo <= {quo[30:0], 1'b0};
                    end
                    if (cnt == 5'd0) state <= DIV_DONE;
                    else             cnt   <= cnt - 5'd1;
                end
                DIV_DONE: state <= DIV_IDLE;
                default:  state <= DIV_IDLE;
            endcase
        end
    end

    assign busy   = (state == DIV_BUSY);
    assign done   = (state == DIV_DONE);
    assign result = !done  ? 32'd0 :
                    is_rem ? (neg_r ? -rem : rem) :
                             (neg_q ? -quo : quo);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU/branch compare, multi-cycle divider stalling the pipe via fc.
// Zero latency for non-divide ops; divides hold stall until the divider reaches DONE.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] idex_op_a_i,
    input  logic [31:0] idex_op_b_i,
    input  logic [4:0]  idex_ALUctrl_i,
    input  logic [4:0]  idex_reg_waddr_i,
    input  logic        idex_reg_we_i,
    input  logic        idex_btype_flag_i,
    input  logic [31:0] idex_btype_jump_pc_i,
    input  logic        idex_mtype_i,
    input  logic        idex_mem_rw_i,
    input  logic [1:0]  idex_mem_width_i,
    input  logic [31:0] idex_mem_wr_data_i,
    input  logic        idex_mem_rdtype_i,
    input  logic        fc_flush_ex_i,
    output logic [31:0] ex_result_o,
    output logic [4:0]  ex_reg_waddr_o,
    output logic        ex_reg_we_o,
    output logic        ex_mtype_o,
    output logic        ex_mem_rw_o,
    output logic [1:0]  ex_mem_width_o,
    output logic [31:0] ex_mem_wr_data_o,
    output logic        ex_mem_rdtype_o,
    output logic        ex_jump_flag_o,
    output logic [31:0] ex_jump_pc_o,
    output logic        ex_stall_req_o
);

    logic [31:0] a, b, alu_res, div_res;
    logic [4:0]  shamt;
    logic        is_div, is_branch, cmp_true, div_busy, div_done;

    assign a         = idex_op_a_i;
    assign b         = idex_op_b_i;
    assign shamt     = b[4:0];
    assign is_div    = is_div_op(idex_ALUctrl_i);
    assign is_branch = is_branch_op(idex_ALUctrl_i);

    always_comb begin
        alu_res = a + b;
        unique case (idex_ALUctrl_i)
            OP_SUB:   alu_res = a - b;
            OP_SLL:   alu_res = a << shamt;
            OP_SLT:   alu_res = {31'd0, $signed(a) < $signed(b)};
            OP_SLTU:  alu_res = {31'd0, a < b};
            OP_XOR:   alu_res = a ^ b;
            OP_SRL:   alu_res = a >> shamt;
            OP_SRA:   alu_res = $signed(a) >>> shamt;
            OP_OR:    alu_res = a | b;
            OP_AND:   alu_res = a & b;
            OP_PASSB: alu_res = b;
            default:  alu_res = a + b;
        endcase
    end

    always_comb begin
        cmp_true = 1'b0;
        unique case (idex_ALUctrl_i)
            OP_BEQ:  cmp_true = (a == b);
            OP_BNE:  cmp_true = (a != b);
            OP_BLT:  cmp_true = ($signed(a) <  $signed(b));
            OP_BGE:  cmp_true = ($signed(a) >= $signed(b));
            OP_BLTU: cmp_true = (a <  b);
            OP_BGEU: cmp_true = (a >= b);
            default: cmp_true = 1'b0;
        endcase
    end

    div_unit u_div (
        .clk    (clk),
        .rst    (rst),
        .start  (is_div),
        .op     (idex_ALUctrl_i),
        .a      (a),
        .b      (b),
        .flush  (fc_flush_ex_i),
        .busy   (div_busy),
        .done   (div_done),
        .result (div_res)
    );

    assign ex_stall_req_o = is_div & ~div_done;

    assign ex_result_o      = is_div    ? div_res :
                              is_branch ? 32'd0   : alu_res;
    assign ex_jump_flag_o   = idex_btype_flag_i & is_branch & cmp_true;
    assign ex_jump_pc_o     = idex_btype_jump_pc_i;

    // A held instruction must not commit anything until the divider result is ready.
    assign ex_reg_we_o      = idex_reg_we_i & ~(ex_stall_req_o | div_busy);
    assign ex_mtype_o       = idex_mtype_i  & ~(ex_stall_req_o | div_busy);
    assign ex_reg_waddr_o   = idex_reg_waddr_i;
    assign ex_mem_rw_o      = idex_mem_rw_i;
    assign ex_mem_width_o   = idex_mem_width_i;
    assign ex_mem_wr_data_o = idex_mem_wr_data_i;
    assign ex_mem_rdtype_o  = idex_mem_rdtype_i;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: expected results queued at issue, popped when stall drops.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] idex_op_a_i, idex_op_b_i, idex_btype_jump_pc_i, idex_mem_wr_data_i;
    logic [4:0]  idex_ALUctrl_i, idex_reg_waddr_i;
    logic        idex_reg_we_i, idex_btype_flag_i, idex_mtype_i, idex_mem_rw_i, idex_mem_rdtype_i;
    logic [1:0]  idex_mem_width_i;
    logic        fc_flush_ex_i;
    logic [31:0] ex_result_o, ex_mem_wr_data_o, ex_jump_pc_o;
    logic [4:0]  ex_reg_waddr_o;
    logic        ex_reg_we_o, ex_mtype_o, ex_mem_rw_o, ex_mem_rdtype_o, ex_jump_flag_o, ex_stall_req_o;
    logic [1:0]  ex_mem_width_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic        jf;
        int          stall;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rst(rst),
        .idex_op_a_i(idex_op_a_i), .idex_op_b_i(idex_op_b_i),
        .idex_ALUctrl_i(idex_ALUctrl_i), .idex_reg_waddr_i(idex_reg_waddr_i),
        .idex_reg_we_i(idex_reg_we_i), .idex_btype_flag_i(idex_btype_flag_i),
        .idex_btype_jump_pc_i(idex_btype_jump_pc_i), .idex_mtype_i(idex_mtype_i),
        .idex_mem_rw_i(idex_mem_rw_i), .idex_mem_width_i(idex_mem_width_i),
        .idex_mem_wr_data_i(idex_mem_wr_data_i), .idex_mem_rdtype_i(idex_mem_rdtype_i),
        .fc_flush_ex_i(fc_flush_ex_i),
        .ex_result_o(ex_result_o), .ex_reg_waddr_o(ex_reg_waddr_o), .ex_reg_we_o(ex_reg_we_o),
        .ex_mtype_o(ex_mtype_o), .ex_mem_rw_o(ex_mem_rw_o), .ex_mem_width_o(ex_mem_width_o),
        .ex_mem_wr_data_o(ex_mem_wr_data_o), .ex_mem_rdtype_o(ex_mem_rdtype_o),
        .ex_jump_flag_o(ex_jump_flag_o), .ex_jump_pc_o(ex_jump_pc_o),
        .ex_stall_req_o(ex_stall_req_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_result(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb_;
        sa  = a;
        sb_ = b;
        case (op)
            OP_ADD:   return a + b;
            OP_SUB:   return a - b;
            OP_SLL:   return a << b[4:0];
            OP_SLT:   return (sa < sb_) ? 32'd1 : 32'd0;
            OP_SLTU:  return (a < b) ? 32'd1 : 32'd0;
            OP_XOR:   return a ^ b;
            OP_SRL:   return a >> b[4:0];
            OP_SRA:   return sa >>> b[4:0];
            OP_OR:    return a | b;
            OP_AND:   return a & b;
            OP_PASSB: return b;
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: return 32'd0;
            OP_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb_;
            end
            OP_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb_;
            end
            OP_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REMU:  return (b == 0) ? a : a % b;
            default:  return a + b;
        endcase
    endfunction

    function automatic logic model_jump(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic flag);
        logic signed [31:0] sa, sb_;
        sa  = a;
        sb_ = b;
        case (op)
            OP_BEQ:  return flag && (a == b);
            OP_BNE:  return flag && (a != b);
            OP_BLT:  return flag && (sa < sb_);
            OP_BGE:  return flag && (sa >= sb_);
            OP_BLTU: return flag && (a < b);
            OP_BGEU: return flag && (a >= b);
            default: return 1'b0;
        endcase
    endfunction

    function automatic int model_stall(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op < OP_DIV || op > OP_REMU) return 0;
        if (b == 0) return 1;
        if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic flag, input logic [31:0] pc, input logic we);
        idex_ALUctrl_i       = op;
        idex_op_a_i          = a;
        idex_op_b_i          = b;
        idex_btype_flag_i    = flag;
        idex_btype_jump_pc_i = pc;
        idex_reg_we_i        = we;
        idex_reg_waddr_i     = we ? 5'd7 : 5'd0;
        idex_mtype_i         = we;
        idex_mem_rw_i        = we;
        idex_mem_width_i     = we ? 2'd2 : 2'd0;
        idex_mem_wr_data_i   = a ^ 32'h5A5A_5A5A;
        idex_mem_rdtype_i    = 1'b0;
    endtask

    task automatic run(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic flag, input logic [31:0] pc);
        exp_t e;
        int   ns;
        @(posedge clk); #1;
        drive(op, a, b, flag, pc, 1'b1);
        e.tag   = tag;
        e.res   = model_result(op, a, b);
        e.jf    = model_jump(op, a, b, flag);
        e.stall = model_stall(op, a, b);
        sb.push_back(e);
        ns = 0;
        @(negedge clk);
        while (ex_stall_req_o && ns < 100) begin
            if (ns == 0) begin
                check_eq({tag, "_we_held"}, {31'd0, ex_reg_we_o}, 32'd0);
                check_eq({tag, "_mtype_held"}, {31'd0, ex_mtype_o}, 32'd0);
            end
            ns++;
            @(negedge clk);
        end
        e = sb.pop_front();
        check_eq({e.tag, "_stall"}, 32'(ns), 32'(e.stall));
        check_eq({e.tag, "_res"}, ex_result_o, e.res);
        check_eq({e.tag, "_jump"}, {31'd0, ex_jump_flag_o}, {31'd0, e.jf});
        check_eq({e.tag, "_we"}, {31'd0, ex_reg_we_o}, 32'd1);
    endtask

    initial begin
        rst           = 1'b1;
        fc_flush_ex_i = 1'b0;
        drive(OP_ADD, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_stall", {31'd0, ex_stall_req_o}, 32'd0);
        check_eq("rst_res",   ex_result_o, 32'd0);
        check_eq("rst_we",    {31'd0, ex_reg_we_o}, 32'd0);
        check_eq("rst_jump",  {31'd0, ex_jump_flag_o}, 32'd0);

        run("add",   OP_ADD,  32'd7, 32'd5, 1'b0, 32'd0);
        check_eq("waddr_pass", {27'd0, ex_reg_waddr_o}, 32'd7);
        check_eq("wdata_pass", ex_mem_wr_data_o, 32'd7 ^ 32'h5A5A_5A5A);
        run("sub",   OP_SUB,  32'd5, 32'd7, 1'b0, 32'd0);
        run("sra",   OP_SRA,  32'h8000_0000, 32'd4, 1'b0, 32'd0);
        run("srl",   OP_SRL,  32'h8000_0000, 32'd36, 1'b0, 32'd0);
        run("sll",   OP_SLL,  32'h0000_0003, 32'd31, 1'b0, 32'd0);
        run("sltu",  OP_SLTU, 32'd1, 32'hFFFF_FFFF, 1'b0, 32'd0);
        run("slt",   OP_SLT,  32'd1, 32'hFFFF_FFFF, 1'b0, 32'd0);
        run("xor",   OP_XOR,  32'hF0F0_1234, 32'h0FF0_4321, 1'b0, 32'd0);
        run("and",   OP_AND,  32'hF0F0_1234, 32'h0FF0_4321, 1'b0, 32'd0);
        run("or",    OP_OR,   32'hF0F0_1234, 32'h0FF0_4321, 1'b0, 32'd0);
        run("passb", OP_PASSB,32'h1111_1111, 32'hCAFE_BABE, 1'b0, 32'd0);
        run("op25",  5'd25,   32'd40, 32'd2, 1'b0, 32'd0);
        run("blt",   OP_BLT,  32'hFFFF_FFFF, 32'd0, 1'b1, 32'h100);
        check_eq("blt_pc", ex_jump_pc_o, 32'h100);
        run("bgeu",  OP_BGEU, 32'hFFFF_FFFF, 32'd0, 1'b1, 32'h100);
        run("beq_noflag", OP_BEQ, 32'd3, 32'd3, 1'b0, 32'h200);
        run("bne",   OP_BNE,  32'd3, 32'd4, 1'b1, 32'h300);

        run("div",   OP_DIV,  -32'sd7, 32'd2, 1'b0, 32'd0);
        run("rem",   OP_REM,  -32'sd7, 32'd2, 1'b0, 32'd0);
        run("divu",  OP_DIVU, 32'd100, 32'd7, 1'b0, 32'd0);
        run("remu",  OP_REMU, 32'd100, 32'd7, 1'b0, 32'd0);
        run("div_neg_b", OP_DIV, 32'd100, -32'sd7, 1'b0, 32'd0);
        run("divu_big",  OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0);
        run("div0",  OP_DIV,  32'd9, 32'd0, 1'b0, 32'd0);
        run("remu0", OP_REMU, 32'd9, 32'd0, 1'b0, 32'd0);
        run("rem0_neg", OP_REM, -32'sd9, 32'd0, 1'b0, 32'd0);
        run("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0);
        run("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0);

        // Flush mid-division; the ID/EX register bubbles alongside the flush.
        @(posedge clk); #1;
        drive(OP_DIV, -32'sd7, 32'd2, 1'b0, 32'd0, 1'b1);
        repeat (10) @(posedge clk);
        #1 fc_flush_ex_i = 1'b1;
        @(negedge clk);
        check_eq("flush_busy_we", {31'd0, ex_reg_we_o}, 32'd0);
        @(posedge clk); #1;
        fc_flush_ex_i = 1'b0;
        drive(OP_ADD, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        check_eq("flush_stall", {31'd0, ex_stall_req_o}, 32'd0);
        run("div_after_flush", OP_DIVU, 32'd1000, 32'd3, 1'b0, 32'd0);

        // Reset mid-division; ID/EX outputs zero under reset.
        @(posedge clk); #1;
        drive(OP_REMU, 32'd1000, 32'd3, 1'b0, 32'd0, 1'b1);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        drive(OP_ADD, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        check_eq("rst_mid_we", {31'd0, ex_reg_we_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_stall", {31'd0, ex_stall_req_o}, 32'd0);
        check_eq("rst_mid_res",   ex_result_o, 32'd0);
        check_eq("rst_mid_jump",  {31'd0, ex_jump_flag_o}, 32'd0);
        run("div_after_rst", OP_REM, 32'd1001, -32'sd10, 1'b0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage RV32IM core, directly downstream of the ID/EX pipeline register and upstream of the EX/MEM register. It evaluates the single-cycle ALU and branch-compare operations combinationally and resolves taken branches to flow control (fc). It also contains an iterative radix-2 divider for DIV/DIVU/REM/REMU, which stalls the pipeline through fc while it runs.

## Interface
- No parameters; operation codes come from the shared header.
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous, active-high reset
- idex_op_a_i / idex_op_b_i  in  32  source operands
- idex_ALUctrl_i  in  5  operation code
- idex_reg_waddr_i  in  5;  idex_reg_we_i  in  1  destination register address and write enable
- idex_btype_flag_i  in  1  branch instruction; idex_btype_jump_pc_i  in  32  branch target
- idex_mtype_i, idex_mem_rw_i (1), idex_mem_width_i (2), idex_mem_wr_data_i (32), idex_mem_rdtype_i (1)  in  memory controls
- fc_flush_ex_i  in  1  abort any in-flight division
- ex_result_o  out  32  ALU, divider or memory-address result
- ex_reg_waddr_o (5), ex_reg_we_o (1), ex_mtype_o, ex_mem_rw_o, ex_mem_width_o, ex_mem_wr_data_o, ex_mem_rdtype_o  out  passthrough to EX/MEM
- ex_jump_flag_o  out  1  branch taken; ex_jump_pc_o  out  32  branch target
- ex_stall_req_o  out  1  request to fc to hold PC/IF/ID/IDEX and to bubble EX/MEM

## Operation
- ALU codes: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB=10.
- Branch codes: BEQ=11, BNE=12, BLT=13, BGE=14, BLTU=15, BGEU=16.
- Divide codes: DIV=17, DIVU=18, REM=19, REMU=20. Codes 21–31 behave as ADD.
- Shift amount is op_b[4:0]. SLT/SLTU produce 32'h0 or 32'h1.
- Branch codes: ex_jump_flag_o = btype_flag AND compare true. ex_jump_pc_o = jump_pc. ex_result_o = 0 and ex_reg_we_o is passed through unchanged.
- Load/store: the ID stage issues ADD, so ex_result_o is the effective address.
- Divider FSM states: IDLE, BUSY, DONE.
  - IDLE, divide code present: latch |a|, |b| (for signed ops), the result sign and the op type. Load counter = 31. Go to BUSY.
  - Special cases go from IDLE straight to DONE:
    - b == 0: quotient 32'hFFFF_FFFF, remainder = a.
    - DIV/REM with a = 32'h8000_0000 and b = 32'hFFFF_FFFF: quotient 32'h8000_0000, remainder 0.
  - BUSY: one restoring step per cycle (shift remainder:quotient left, trial subtract, set quotient bit). Counter decrements. Go to DONE after the step with counter == 0, i.e. 32 BUSY cycles.
  - DONE: apply sign correction. The quotient is negated if the operand signs differ; the remainder takes the sign of a. Drive ex_result_o, then return to IDLE next cycle.
- ex_stall_req_o = divide code present AND state != DONE. Asserted combinationally in the issue cycle.
- While stalled, the passthrough outputs carry the held instruction, but ex_reg_we_o and ex_mtype_o are forced to 0 so no partial result is committed.

## Timing
- Non-divide ops: zero latency, pure combinational path from idex inputs to outputs.
- Normal divide: stall high for 33 cycles (issue cycle + 32 BUSY). The result is valid in the DONE cycle (cycle 33 after issue); stall is low in that cycle and EX/MEM captures it.
- Special-case divide: stall high for 1 cycle; result in the next cycle.
- Divide immediately followed by a divide: the second one is issued from IDLE in the cycle after DONE. There is no dead cycle beyond that.
- fc_flush_ex_i in any state: next state IDLE, counter 0. Flush takes priority over FSM progress.
- rst: state IDLE, counter 0, divider registers 0. ex_stall_req_o is 0 from the first cycle after reset. Combinational outputs follow the ID/EX register's zeroed outputs: result 0, we 0, jump_flag 0.

## Structure
- Operation codes are shared with ID and belong in the common define header. No local literals.
- Sub-module div_unit: FSM, counter and datapath. Ports: start, op, a, b, flush, busy, done, result.
- ex_stage holds the ALU, the branch compare, the passthrough logic and the stall gating.

## Test plan
- ADD 7+5 → 12. SUB 5−7 → 32'hFFFF_FFFE. SRA 32'h8000_0000 by 4 → 32'hF800_0000. SLTU 1 < 32'hFFFF_FFFF → 1.
- BLT a=−1, b=0, flag=1, pc=32'h100 → jump_flag 1, jump_pc 32'h100. BGEU on the same operands → jump_flag 0.
- DIV −7 / 2 → stall high for 33 cycles, then −3. REM −7 / 2 → −1. DIVU 100 / 7 → 14.
- DIV by 0 with a=9 → 1-cycle stall, result 32'hFFFF_FFFF. REMU by 0 → 9.
- DIV 32'h8000_0000 / −1 → 32'h8000_0000 after a 1-cycle stall.
- Flush at BUSY cycle 10 → stall drops next cycle, FSM in IDLE. rst asserted mid-BUSY → same behaviour, no write enable is seen.
